// File: rtl/vdp_vga_display_if.sv
// ---------------------------------------------------------------------------
// vdp_vga_display_if : VRAM/CRAM read bus between the VGA back end and memories
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vdp_vga_display_if;
    logic [7:0][13:0] VRAM_VGA_addr;
    logic [7:0][7:0]  VRAM_VGA_data_out;
    logic [4:0]       CRAM_VGA_addr;
    logic [5:0]       CRAM_VGA_data_out;

    modport master (
        output VRAM_VGA_addr,
        output CRAM_VGA_addr,
        input  VRAM_VGA_data_out,
        input  CRAM_VGA_data_out
    );

    modport slave (
        input  VRAM_VGA_addr,
        input  CRAM_VGA_addr,
        output VRAM_VGA_data_out,
        output CRAM_VGA_data_out
    );
endinterface

`default_nettype wire

// File: rtl/vdp_vga_display.sv
// ---------------------------------------------------------------------------
// vdp_vga_display : 640x480@60 VGA timing and 2x-scaled Mode-4 background render
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vdp_vga_display (
    input  logic                     clk,
    input  logic                     rst_L,
    input  logic [7:0]               R2,
    vdp_vga_display_if.master        mem,
    output logic [9:0]               col,
    output logic [8:0]               row,
    output logic [3:0]               VGA_R,
    output logic [3:0]               VGA_G,
    output logic [3:0]               VGA_B,
    output logic                     HSync,
    output logic                     VSync
);

    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_LAST       = 10'd524;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] WIN_X0       = 10'd64;
    localparam logic [9:0] WIN_X1       = 10'd576;
    localparam logic [9:0] WIN_Y0       = 10'd48;
    localparam logic [9:0] WIN_Y1       = 10'd432;

    logic [1:0]  phase;
    logic [9:0]  hcount;
    logic [9:0]  vcount;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            phase  <= 2'd0;
            hcount <= 10'd0;
            vcount <= 10'd0;
        end else begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
                if (hcount == H_LAST) begin
                    hcount <= 10'd0;
                    vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    logic        active;
    logic [9:0]  hoff;
    logic [9:0]  voff;
    logic [7:0]  src_x;
    logic [7:0]  src_y;
    logic [13:0] name_addr;
    logic [7:0]  name_lo;
    logic [7:0]  name_hi;
    logic [8:0]  tile;
    logic [2:0]  line;
    logic [2:0]  bit_idx;
    logic [3:0]  pix_bits;
    logic [5:0]  colour;

    assign active  = (hcount >= WIN_X0) && (hcount < WIN_X1) &&
                     (vcount >= WIN_Y0) && (vcount < WIN_Y1);
    assign hoff    = hcount - WIN_X0;
    assign voff    = vcount - WIN_Y0;
    assign src_x   = hoff[8:1];
    assign src_y   = voff[8:1];

    // Name entry is 2 bytes per tile, 32 tiles per row.
    assign name_addr = {R2[3:1], 11'b0} + {3'b000, src_y[7:3], src_x[7:3], 1'b0};
    assign name_lo   = mem.VRAM_VGA_data_out[0];
    assign name_hi   = mem.VRAM_VGA_data_out[1];
    assign tile      = {name_hi[0], name_lo};
    assign line      = name_hi[2] ? ~src_y[2:0] : src_y[2:0];
    assign bit_idx   = name_hi[1] ? src_x[2:0] : ~src_x[2:0];

    // Addresses depend only on the counters and held read data, so each
    // stage's data stays valid for the rest of the pixel period.
    always_comb begin
        mem.VRAM_VGA_addr    = '0;
        mem.VRAM_VGA_addr[0] = name_addr;
        mem.VRAM_VGA_addr[1] = name_addr + 14'd1;
        pix_bits             = '0;
        for (int p = 0; p < 4; p++) begin
            mem.VRAM_VGA_addr[p + 2] = {tile, line, 2'(p)};
            pix_bits[p]              = mem.VRAM_VGA_data_out[p + 2][bit_idx];
        end
    end

    assign mem.CRAM_VGA_addr = {name_hi[3], pix_bits};
    assign colour            = mem.CRAM_VGA_data_out;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            VGA_R <= 4'h0;
            VGA_G <= 4'h0;
            VGA_B <= 4'h0;
            HSync <= 1'b1;
            VSync <= 1'b1;
        end else if (phase == 2'd3) begin
            if (active) begin
                VGA_R <= {colour[1:0], colour[1:0]};
                VGA_G <= {colour[3:2], colour[3:2]};
                VGA_B <= {colour[5:4], colour[5:4]};
            end else begin
                VGA_R <= 4'h0;
                VGA_G <= 4'h0;
                VGA_B <= 4'h0;
            end
            HSync <= !((hcount >= H_SYNC_START) && (hcount <= H_SYNC_END));
            VSync <= !((vcount >= V_SYNC_START) && (vcount <= V_SYNC_END));
        end
    end

    assign col = hcount;
    assign row = vcount[8:0];

    logic unused_ok;
    assign unused_ok = ^{R2[7:4], R2[0], name_hi[7:4], hoff[9], hoff[0],
                         voff[9], voff[0], mem.VRAM_VGA_data_out[7:6]};

endmodule

`default_nettype wire

// File: tb/tb_vdp_vga_display.sv
// ---------------------------------------------------------------------------
// tb_vdp_vga_display : directed checks of VGA timing, reset and background render
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vdp_vga_display;

    logic       clk;
    logic       rst_L;
    logic [7:0] R2;
    logic [9:0] col;
    logic [8:0] row;
    logic [3:0] VGA_R, VGA_G, VGA_B;
    logic       HSync, VSync;

    vdp_vga_display_if mem_if ();

    vdp_vga_display dut (
        .clk   (clk),
        .rst_L (rst_L),
        .R2    (R2),
        .mem   (mem_if),
        .col   (col),
        .row   (row),
        .VGA_R (VGA_R),
        .VGA_G (VGA_G),
        .VGA_B (VGA_B),
        .HSync (HSync),
        .VSync (VSync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory models, one clock of latency.
    logic [7:0] vram [16384];
    logic [5:0] cram [32];

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            mem_if.VRAM_VGA_data_out[i] <= vram[mem_if.VRAM_VGA_addr[i]];
        mem_if.CRAM_VGA_data_out <= cram[mem_if.CRAM_VGA_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_col(input string tag, input int target);
        int n;
        n = 0;
        while (col !== target[9:0] && n < 3400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3400) check_value({tag, "_timeout"}, 32'(col), 32'(target));
    endtask

    // Output for screen column c is visible while col == c+1.
    task automatic pixel(input string tag, input int c, input logic [11:0] exp);
        wait_col(tag, c + 1);
        check_value(tag, {20'h0, VGA_R, VGA_G, VGA_B}, {20'h0, exp});
    endtask

    task automatic vsync_at(input string tag, input logic [9:0] vc, input logic exp);
        force dut.vcount = vc;
        repeat (8) @(negedge clk);
        check_value(tag, 32'(VSync), 32'(exp));
    endtask

    task automatic start_line(input string tag, input logic [9:0] vc);
        force dut.vcount = vc;
        wait_col(tag, 0);
    endtask

    int n, low, per;

    initial begin
        rst_L = 1'b0;
        R2    = 8'hFF;
        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        for (int i = 0; i < 32; i++) cram[i] = 6'h00;
        vram[14'h3800] = 8'h01;
        vram[14'h3801] = 8'h00;
        vram[14'h0020] = 8'h80;
        cram[0]        = 6'b000111;
        cram[1]        = 6'b110011;

        repeat (3) @(negedge clk);
        rst_L = 1'b1;

        // Reset asserted asynchronously while HSync is low mid-line.
        wait_col("pre_reset", 700);
        check_value("hsync_low_pre_reset", 32'(HSync), 32'd0);
        #2 rst_L = 1'b0;
        #1;
        check_value("reset_col", 32'(col), 32'd0);
        check_value("reset_row", 32'(row), 32'd0);
        check_value("reset_hsync", 32'(HSync), 32'd1);
        check_value("reset_vsync", 32'(VSync), 32'd1);
        check_value("reset_rgb", {20'h0, VGA_R, VGA_G, VGA_B}, 32'd0);

        @(negedge clk);
        rst_L = 1'b1;
        repeat (3) @(negedge clk);
        check_value("col_after_3", 32'(col), 32'd0);
        @(negedge clk);
        check_value("col_after_4", 32'(col), 32'd1);

        // Horizontal sync timing.
        wait_col("hs_start", 656);
        check_value("hsync_high_before", 32'(HSync), 32'd1);
        n = 0;
        while (HSync !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check_value("hsync_latency", 32'(n), 32'd4);
        low = 0;
        while (HSync === 1'b0 && low < 1000) begin @(negedge clk); low++; end
        check_value("hsync_width", 32'(low), 32'd384);
        per = low;
        while (HSync === 1'b1 && per < 4000) begin @(negedge clk); per++; end
        check_value("line_period", 32'(per), 32'd3200);

        // Vertical sync decode around the sync lines.
        vsync_at("vsync_489", 10'd489, 1'b1);
        vsync_at("vsync_490", 10'd490, 1'b0);
        vsync_at("vsync_491", 10'd491, 1'b0);
        vsync_at("vsync_492", 10'd492, 1'b1);
        vsync_at("vsync_524", 10'd524, 1'b1);

        // Plain render, top row of the window.
        start_line("l48", 10'd48);
        pixel("r48_c63_border", 63,  12'h000);
        pixel("r48_c64",        64,  12'hF0F);
        pixel("r48_c65",        65,  12'hF0F);
        pixel("r48_c66",        66,  12'hF50);
        pixel("r48_c575",       575, 12'hF50);
        pixel("r48_c576_border",576, 12'h000);
        pixel("r48_c640_blank", 640, 12'h000);

        start_line("l49", 10'd49);
        pixel("r49_c64", 64, 12'hF0F);
        pixel("r49_c66", 66, 12'hF50);

        start_line("l47", 10'd47);
        pixel("r47_c64_border", 64, 12'h000);

        start_line("l431", 10'd431);
        pixel("r431_c64", 64, 12'hF50);

        start_line("l432", 10'd432);
        pixel("r432_c64_border", 64, 12'h000);

        // Horizontal flip and palette 1.
        wait_col("flip_setup", 700);
        vram[14'h3801] = 8'h0A;
        cram[16]       = 6'b010000;
        cram[17]       = 6'b001100;
        start_line("flip", 10'd48);
        pixel("flip_c64", 64, 12'h005);
        pixel("flip_c76", 76, 12'h005);
        pixel("flip_c78", 78, 12'h0F0);
        pixel("flip_c79", 79, 12'h0F0);

        // Vertical flip on tile row 1, plane 1.
        wait_col("vflip_setup", 700);
        vram[14'h3840] = 8'h01;
        vram[14'h3841] = 8'h04;
        vram[14'h003D] = 8'h01;
        cram[2]        = 6'b100100;
        start_line("vflip", 10'd64);
        pixel("vflip_c64", 64, 12'hF50);
        pixel("vflip_c78", 78, 12'h05A);

        // Name-table base follows R2.
        wait_col("r2_setup", 700);
        R2 = 8'h00;
        start_line("r2", 10'd48);
        pixel("r2_base0_c64", 64, 12'hF50);
        pixel("r2_base0_c78", 78, 12'hF50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vdp_vga_display.md
# vdp_vga_display

Video-output back end of the VDP. It generates 640x480@60 Hz VGA timing from a 100 MHz system clock, with one pixel every 4 clocks. It renders the Mode-4 background (256x192, 32x24 tiles) scaled 2x and centred, and drives 4-bit-per-channel VGA colour. VRAM (8 parallel read ports) and CRAM (1 read port) are external synchronous-read memories with 1-cycle latency; this block only issues addresses and consumes data.

## Interface
- No parameters.
- clk  in  1  system clock, 100 MHz
- rst_L  in  1  asynchronous, active-low reset
- R2  in  8  VDP register 2; name-table base = {R2[3:1], 11'b0}
- VRAM_VGA_data_out  in  8x8  VRAM read data, port i answers VRAM_VGA_addr[i] one clock later
- CRAM_VGA_data_out  in  6  CRAM colour {B[1:0],G[1:0],R[1:0]}, 1-clock latency
- VRAM_VGA_addr  out  8x14  VRAM read addresses (combinational)
- CRAM_VGA_addr  out  5  CRAM read address (combinational)
- col  out  10  horizontal counter 0..799
- row  out  9  vertical counter [8:0]; meaningful only for 0..479
- VGA_R, VGA_G, VGA_B  out  4 each  registered colour
- HSync, VSync  out  1 each  registered, active-low syncs

## Operation
- Phase counter 0..3 runs every clock. hcount advances when phase==3 and wraps 799->0. vcount advances on hcount wrap and wraps 524->0.
- Horizontal timing: visible 0-639, front porch 640-655, sync 656-751 (HSync=0), back porch 752-799.
- Vertical timing: visible 0-479, front porch 480-489, sync 490-491 (VSync=0), back porch 492-524.
- Active window: hcount 64..575 and vcount 48..431. Source pixel x=(hcount-64)>>1 (0..255), y=(vcount-48)>>1 (0..191). Everything else (border and blanking) outputs RGB=0.
- Name-table fetch:
  - addr = base + ((y>>3)*32 + (x>>3))*2.
  - Port0 reads addr (low byte = tile[7:0]); port1 reads addr+1 (high byte).
  - High byte: bit0 = tile[8], bit1 = hflip, bit2 = vflip, bit3 = palette select. Bit4 (priority) is ignored.
- Pattern fetch:
  - line = vflip ? 7-(y&7) : (y&7).
  - Ports 2..5 read tile*32 + line*4 + p, for p = 0..3 (bitplanes).
  - Ports 6,7 drive 0.
- Pixel bit index b = hflip ? (x&7) : 7-(x&7). CRAM_VGA_addr = {pal, plane3[b], plane2[b], plane1[b], plane0[b]}.
- Colour expansion: each 2-bit channel c maps to 4-bit {c,c} (e.g. 2'b10 -> 4'hA). R = data[1:0], G = data[3:2], B = data[5:4].
- All 14-bit address arithmetic wraps modulo 16K.

## Timing
- Within one pixel period (counters constant):
  - phase0: name addresses valid.
  - phase1: name data valid, pattern addresses valid.
  - phase2: pattern data valid, CRAM address valid.
  - phase3: CRAM data valid.
- RGB, HSync and VSync are registered together on the clock edge that ends phase3. They are computed from that period's hcount/vcount, so colour and syncs stay aligned.
- Latency: 4 clocks from counter change to the corresponding output.
- Reset (async, any time): phase, hcount and vcount = 0; HSync = VSync = 1; RGB = 0. After release, counting restarts at pixel (0,0), phase0.
- Frame period: 800*525*4 = 1,680,000 clocks.
- R2 is sampled combinationally every fetch. A change mid-line takes effect on the next pixel fetched.

## Test plan
- Reset: assert rst_L=0 mid-line -> HSync=VSync=1, RGB=0, col=row=0 immediately. After release, col reaches 1 after 4 clocks.
- Horizontal sync: after reset, HSync falls registering hcount=656 (clock 2627 post-release) and stays low 384 clocks. Line period is 3200 clocks.
- Vertical sync: VSync is low for exactly 2 lines (6400 clocks) starting at line 490. Frame period is 1,680,000 clocks.
- Pixel render:
  - Setup: R2=8'hFF (base 0x3800); VRAM[0x3800]=0x01, VRAM[0x3801]=0x00; VRAM[0x20]=0x80, other tile-1 bytes 0; CRAM[1]=6'b110011.
  - Expected: screen cols 64-65, rows 48-49 give R=F, G=0, B=F; col 66 gives CRAM[0] colour.
- Flip and palette:
  - Setup: VRAM[0x3801]=0x0A (hflip, palette 1); CRAM[17]=6'b001100.
  - Expected: pixel at source x=7 (cols 78-79) gives G=F, R=B=0; source x=0 uses CRAM[16].
- Border: any pixel at col<64, col>=576, row<48 or row>=432, or in the blanking interval -> RGB=0 regardless of VRAM/CRAM contents.
